// File: rtl/qos_wrr_arbiter.sv
// QoS virtual-channel arbiter: round-robin, strict priority, weighted round-robin or disabled.
// One-cycle registered grant path; a mode change restarts the search at channel 0.
module qos_wrr_arbiter #(
    parameter int N_CH  = 4,
    parameter int W_W   = 4,
    parameter int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  enb,
    input  logic [1:0]            mode,
    input  logic [N_CH-1:0]       req,
    input  logic [N_CH*W_W-1:0]   weight,
    output logic [N_CH-1:0]       grant,
    output logic                  grant_valid,
    output logic [IDX_W-1:0]      grant_idx,
    output logic [W_W-1:0]        credit_o
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CH - 1);

    logic [N_CH-1:0]  grant_q, grant_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [W_W-1:0]   credit_q, credit_d;
    logic [1:0]       mode_q;

    logic             fresh;
    logic [IDX_W-1:0] base_ptr;
    logic [W_W-1:0]   base_credit;
    logic [IDX_W-1:0] rr_k;
    logic [IDX_W-1:0] lo_k;
    logic [IDX_W-1:0] cand;
    logic [W_W-1:0]   load_w [N_CH];
    logic             gnt_en;
    logic [IDX_W-1:0] gnt_k;

    assign fresh       = (mode != mode_q);
    assign base_ptr    = fresh ? LAST : ptr_q;
    assign base_credit = fresh ? '0 : credit_q;

    // Per-channel credit reload value: eff(k)-1, where a zero weight counts as one.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            load_w[k] = (weight[k*W_W +: W_W] == '0) ? '0 : weight[k*W_W +: W_W] - W_W'(1);
        end
    end

    // Cyclic search from base_ptr+1; wrap is explicit so unused index codes never occur.
    always_comb begin
        rr_k = base_ptr;
        cand = base_ptr;
        for (int i = 0; i < N_CH; i++) begin
            cand = (cand == LAST) ? '0 : cand + IDX_W'(1);
            if (req[cand] && (rr_k == base_ptr || !req[rr_k] || i == 0)) begin
                if (!req[rr_k] || rr_k == base_ptr) rr_k = cand;
            end
        end
    end

    always_comb begin
        lo_k = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req[i]) lo_k = IDX_W'(i);
        end
    end

    always_comb begin
        gnt_en   = 1'b0;
        gnt_k    = idx_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        if (enb) begin
            ptr_d    = base_ptr;
            credit_d = base_credit;
            case (mode)
                2'b00: begin
                    credit_d = '0;
                    if (|req) begin
                        gnt_en = 1'b1;
                        gnt_k  = rr_k;
                        ptr_d  = rr_k;
                    end
                end
                2'b01: begin
                    if (|req) begin
                        gnt_en = 1'b1;
                        gnt_k  = lo_k;
                    end
                end
                2'b10: begin
                    if (req[base_ptr] && base_credit != '0) begin
                        gnt_en   = 1'b1;
                        gnt_k    = base_ptr;
                        credit_d = base_credit - W_W'(1);
                    end else if (|req) begin
                        gnt_en   = 1'b1;
                        gnt_k    = rr_k;
                        ptr_d    = rr_k;
                        credit_d = load_w[rr_k];
                    end
                end
                default: ;
            endcase
        end
        grant_d = gnt_en ? ({{(N_CH-1){1'b0}}, 1'b1} << gnt_k) : '0;
        valid_d = gnt_en;
        idx_d   = gnt_en ? gnt_k : idx_q;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            grant_q  <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            ptr_q    <= LAST;
            credit_q <= '0;
            mode_q   <= 2'b00;
        end else begin
            grant_q  <= grant_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            mode_q   <= mode;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_idx   = idx_q;
    assign credit_o    = credit_q;

endmodule

// File: tb/tb_qos_wrr_arbiter.sv
// Directed bench for qos_wrr_arbiter: hand-computed grant/index/credit sequences per mode.
module tb_qos_wrr_arbiter;

    logic        clk = 1'b0;
    logic        reset_L;
    logic        enb;
    logic [1:0]  mode;
    logic [3:0]  req;
    logic [15:0] weight;
    logic [3:0]  grant;
    logic        grant_valid;
    logic [1:0]  grant_idx;
    logic [3:0]  credit_o;

    int n_run  = 0;
    int n_fail = 0;

    qos_wrr_arbiter #(.N_CH(4), .W_W(4)) dut (
        .clk         (clk),
        .reset_L     (reset_L),
        .enb         (enb),
        .mode        (mode),
        .req         (req),
        .weight      (weight),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .credit_o    (credit_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_out(input string tag, input logic [3:0] g, input logic [1:0] idx,
                           input logic [3:0] cr);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".valid"}, 32'(grant_valid), 32'(|g));
        chk({tag, ".idx"}, 32'(grant_idx), 32'(idx));
        chk({tag, ".credit"}, 32'(credit_o), 32'(cr));
    endtask

    task automatic exp_gnt(input string tag, input logic [3:0] g, input logic [1:0] idx);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".valid"}, 32'(grant_valid), 32'(|g));
        chk({tag, ".idx"}, 32'(grant_idx), 32'(idx));
    endtask

    logic [1:0] wrr_idx [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] wrr_cr  [8] = '{4'd2, 4'd1, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd2};

    initial begin
        reset_L = 1'b0;
        enb     = 1'b0;
        mode    = 2'b00;
        req     = 4'b0000;
        weight  = 16'h0000;
        #2;
        exp_out("reset", 4'b0000, 2'd0, 4'd0);
        step();
        step();
        reset_L = 1'b1;

        // Plain round-robin over all four channels.
        enb = 1'b1;
        req = 4'b1111;
        step(); exp_out("rr0", 4'b0001, 2'd0, 4'd0);
        step(); exp_out("rr1", 4'b0010, 2'd1, 4'd0);
        step(); exp_out("rr2", 4'b0100, 2'd2, 4'd0);
        step(); exp_out("rr3", 4'b1000, 2'd3, 4'd0);
        step(); exp_out("rr4", 4'b0001, 2'd0, 4'd0);

        // Reset mid-grant drops the grant without a clock edge.
        reset_L = 1'b0;
        #1;
        exp_out("rst_mid", 4'b0000, 2'd0, 4'd0);
        reset_L = 1'b1;
        req = 4'b1010;
        step(); exp_out("skip0", 4'b0010, 2'd1, 4'd0);
        step(); exp_out("skip1", 4'b1000, 2'd3, 4'd0);
        step(); exp_out("skip2", 4'b0010, 2'd1, 4'd0);
        step(); exp_out("skip3", 4'b1000, 2'd3, 4'd0);
        req = 4'b0000;
        step(); exp_out("noreq", 4'b0000, 2'd3, 4'd0);

        // Weighted RR: weights ch3..ch0 = 0,1,2,3.
        mode   = 2'b10;
        weight = 16'h0123;
        req    = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            step();
            exp_out($sformatf("wrr%0d", i), 4'b0001 << wrr_idx[i], wrr_idx[i], wrr_cr[i]);
        end

        // Forfeit: ch0 weight 3, ch1 weight 1; restart via a disabled cycle.
        mode   = 2'b11;
        weight = 16'h0013;
        req    = 4'b0011;
        step(); exp_gnt("dis_a", 4'b0000, 2'd0);
        mode = 2'b10;
        step(); exp_out("ff0", 4'b0001, 2'd0, 4'd2);
        step(); exp_out("ff1", 4'b0001, 2'd0, 4'd1);
        req = 4'b0010;
        step(); exp_out("ff_drop", 4'b0010, 2'd1, 4'd0);
        req = 4'b0011;
        step(); exp_out("ff_b0", 4'b0001, 2'd0, 4'd2);
        step(); exp_out("ff_b1", 4'b0001, 2'd0, 4'd1);
        step(); exp_out("ff_b2", 4'b0001, 2'd0, 4'd0);
        step(); exp_out("ff_ch1", 4'b0010, 2'd1, 4'd0);

        // Enable gap mid-burst: credit and index hold, burst resumes.
        step(); exp_out("en_b0", 4'b0001, 2'd0, 4'd2);
        step(); exp_out("en_b1", 4'b0001, 2'd0, 4'd1);
        enb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_out($sformatf("enb_off%0d", i), 4'b0000, 2'd0, 4'd1);
        end
        enb = 1'b1;
        step(); exp_out("en_b2", 4'b0001, 2'd0, 4'd0);
        step(); exp_out("en_ch1", 4'b0010, 2'd1, 4'd0);

        mode = 2'b11;
        step(); exp_gnt("dis_b", 4'b0000, 2'd1);

        // Strict priority, then a switch to round-robin restarts at channel 0.
        mode = 2'b01;
        req  = 4'b0110;
        step(); exp_gnt("sp0", 4'b0010, 2'd1);
        step(); exp_gnt("sp1", 4'b0010, 2'd1);
        step(); exp_gnt("sp2", 4'b0010, 2'd1);
        mode = 2'b00;
        step(); exp_out("sw0", 4'b0010, 2'd1, 4'd0);
        step(); exp_out("sw1", 4'b0100, 2'd2, 4'd0);
        step(); exp_out("sw2", 4'b0010, 2'd1, 4'd0);

        // Reset pulse between edges.
        #2;
        reset_L = 1'b0;
        #1;
        exp_out("rst_pulse", 4'b0000, 2'd0, 4'd0);
        reset_L = 1'b1;
        step(); exp_out("post_rst", 4'b0010, 2'd1, 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/qos_wrr_arbiter.md
Name: qos_wrr_arbiter

Overview:
Parametrised multi-mode arbiter for the PCIe QoS path. It selects one of N_CH virtual-channel requesters per cycle and drives a registered one-hot grant toward the egress mux. Supported modes:
- plain round-robin
- strict priority
- weighted round-robin (per-channel programmable weights)
- disabled

It replaces the fixed 4-channel arbiter and adds request masking, weight credits, strict priority and mode-change reinitialisation.

Parameters:
N_CH, 4, number of requesting channels (>=2)
W_W, 4, width of each per-channel weight field
IDX_W, $clog2(N_CH), width of the channel index (derived, do not override)

Ports:
clk  input  1  single clock, rising edge
reset_L  input  1  asynchronous active-low reset
enb  input  1  arbitration enable
mode  input  2  00 round-robin, 01 strict priority, 10 weighted RR, 11 disabled
req  input  N_CH  per-channel request; bit k = channel k
weight  input  N_CH*W_W  packed weights; channel k at [k*W_W +: W_W]
grant  output  N_CH  registered one-hot grant, all-zero when none
grant_valid  output  1  high when grant is non-zero
grant_idx  output  IDX_W  index of the granted channel; holds last value when grant_valid=0
credit_o  output  W_W  remaining WRR credit of the current channel (debug/verif)

Behaviour:
- Internal state:
  - ptr (IDX_W): last-granted channel
  - credit (W_W)
  - mode_q (2): mode of the previous cycle
- Reset (reset_L=0, async): grant=0, grant_valid=0, grant_idx=0, credit=0, credit_o=0, ptr=N_CH-1, mode_q=00. Deassertion takes effect at the next clk edge. Reset mid-grant drops grant immediately.
- Latency: one cycle. Outputs at edge t+1 reflect req/mode/weight sampled at edge t. Outputs are registers only.
- enb=0: grant<=0, grant_valid<=0. ptr, credit and grant_idx hold. mode_q still updates.
- Mode change (mode != mode_q at an edge with enb=1): that cycle's arbitration uses fresh state, ptr=N_CH-1 and credit=0, so the search starts at channel 0. mode_q<=mode every edge.
- Next-requester search: the first k with req[k]=1, scanning ptr+1, ptr+2, … cyclically modulo N_CH. If ptr is the only requester, ptr is chosen again.
- Mode 00 (round-robin): if |req, grant the search result k and set ptr<=k. If no request, grant=0 and ptr holds. credit is forced to 0.
- Mode 01 (strict priority): grant the lowest-index requester. ptr and credit hold.
- Mode 10 (weighted RR):
  - Effective weight eff(k) = weight[k], with 0 treated as 1.
  - Stay: if req[ptr]=1 and credit!=0, grant ptr and set credit<=credit-1.
  - Switch: otherwise, if |req, grant the search result k, set ptr<=k and credit<=eff(k)-1.
  - Channel k therefore receives eff(k) consecutive grants while requesting.
  - Dropping req mid-burst forfeits the remaining credit. The next cycle moves on.
  - If no request, grant=0 and credit holds.
- Mode 11 (disabled): grant=0. ptr and credit hold.
- Weight changes are sampled only at load time and never alter an in-progress credit.
- Arithmetic: credit never underflows; decrement happens only when credit!=0. eff(k)-1 fits in W_W.
- Output invariants: grant_valid == |grant; grant_idx updates only on a valid grant; credit_o == credit.
- N_CH that is not a power of two: index wrap is explicit (N_CH-1 → 0). Unused index codes never appear.

Test Plan:
1. Reset and RR: reset_L=0 then 1, enb=1, mode=00, req=1111.
   - Grants 0001, 0010, 0100, 1000, 0001…
   - grant_idx goes 0,1,2,3,0.
2. RR skipping: req=1010 from reset.
   - Grants alternate 0010, 1000.
   - Then req=0000 → grant=0000, grant_valid=0, grant_idx holds 3.
3. WRR: mode=10, weights {ch3..ch0}={0,1,2,3}, req=1111.
   - Grant sequence per cycle: 0,0,0,1,1,2,3,0,0,0…
   - Weight 0 behaves as 1.
   - credit_o goes 2,1,0,1,0,0,0,2…
4. WRR forfeit: mode=10, weight ch0=3, req=0011 steady.
   - Two grants to ch0.
   - Then drop req[0] for one cycle → the following grant goes to ch1 with credit loaded from ch1's weight.
   - Afterwards the arbiter returns to ch0 with a full 3-grant burst.
5. Strict priority and mode switch: mode=01, req=0110 → constant grant 0010.
   - Switch to mode=00 mid-run → the next grant is 0010 (fresh ptr starts search at 0).
   - RR then continues 0100, 0010.
6. enb/disable/async reset:
   - enb=0 for 3 cycles mid-WRR → grant=0 and credit holds; resume continues the same burst.
   - mode=11 → grant=0.
   - Pulse reset_L low between edges → grant=0 immediately, without waiting for clk.
